// File: rtl/reg_file.sv
// reg_file: 32-entry LEGv8 general-purpose register file.
// NREGS-1 writable WIDTH-bit entries plus a hardwired-zero XZR at index NREGS-1.
// Writes commit at posedge clk behind a wr_en-gated one-hot decode. The two read
// ports are combinational NREGS:1 muxes.
// Optional feature: define REG_FILE_WRITE_BYPASS_EN to forward a pending write
// to a matching read port within the same cycle.
module reg_file #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2
);

  // Reject configurations that would make the decode or the muxes ill-formed.
  if (AW != $clog2(NREGS)) begin : g_bad_aw
    $error("reg_file: AW must equal log2(NREGS)");
  end
  if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("reg_file: NREGS must be a power of two and at least 2");
  end

  localparam logic [AW-1:0] XzrAddr = AW'(NREGS - 1);

  // One enable per writable entry. XZR has no enable, so writes to it are dropped.
  logic [NREGS-2:0]             wr_sel;
  // Read view of all entries. The XZR slot is tied to zero.
  logic [NREGS-1:0][WIDTH-1:0] entry_view;

  // Write-enable decoder: AW-to-one-hot, gated by wr_en.
  // A gated enable keeps an unknown wr_addr harmless while wr_en is low.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NREGS - 1; i++) begin
      wr_sel[i] = wr_en && (wr_addr == AW'(i));
    end
  end

  // Storage: one enabled register per writable entry.
  for (genvar i = 0; i < NREGS - 1; i++) begin : g_entry
    logic [WIDTH-1:0] entry_q;

    // Synchronous active-low clear. Clear wins over a same-cycle write.
    always_ff @(posedge clk) begin
      if (!reset) begin
        entry_q <= '0;
      end else if (wr_sel[i]) begin
        entry_q <= wr_data;
      end
    end

    assign entry_view[i] = entry_q;
  end

  assign entry_view[NREGS-1] = '0;

  // Read port 1: combinational NREGS:1 mux, with optional same-cycle forwarding.
  always_comb begin
    rd_data1 = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_addr1 == AW'(i)) begin
        rd_data1 = entry_view[i];
      end
    end
`ifdef REG_FILE_WRITE_BYPASS_EN
    if (reset && wr_en && (wr_addr == rd_addr1) && (wr_addr != XzrAddr)) begin
      rd_data1 = wr_data;
    end
`endif
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    rd_data2 = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_addr2 == AW'(i)) begin
        rd_data2 = entry_view[i];
      end
    end
`ifdef REG_FILE_WRITE_BYPASS_EN
    if (reset && wr_en && (wr_addr == rd_addr2) && (wr_addr != XzrAddr)) begin
      rd_data2 = wr_data;
    end
`endif
  end

`ifndef REG_FILE_WRITE_BYPASS_EN
  // XzrAddr is needed only by the forwarding path.
  logic unused_xzr;
  assign unused_xzr = ^XzrAddr;
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file using an array model of the register file.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [63:0] rd_data1;
  logic [63:0] rd_data2;

  int checks   = 0;
  int failures = 0;

  logic [63:0] model [32];

  reg_file #(
    .WIDTH (64),
    .NREGS (32),
    .AW    (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value a read port should show right now, given the model and the live write inputs.
  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
`ifdef REG_FILE_WRITE_BYPASS_EN
    if (reset === 1'b1 && wr_en === 1'b1 && wr_addr === a) return wr_data;
`endif
    return model[a];
  endfunction

  // Drive one cycle, advance the model by the register-file rules, then go idle.
  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [63:0] wd);
    reset   = rst;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
    end else if (we && wa != 5'd31) begin
      model[wa] = wd;
    end
    #1;
    reset = 1'b1;
    wr_en = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    step(1'b0, 1'b0, 5'd0, 64'd0);
    step(1'b1, 1'b1, 5'd5, 64'hDEAD);
    rd_addr1 = 5'd5;
    #1;
    checks++;
    if (rd_data1 !== 64'hDEAD) begin
      failures++;
      $display("FAIL reset_pre_x5: got %h want %h", rd_data1, 64'hDEAD);
    end
    step(1'b0, 1'b1, 5'd7, 64'h55);
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(31 - a);
      #1;
      checks++;
      if (rd_data1 !== 64'd0 || rd_data2 !== 64'd0) begin
        failures++;
        $display("FAIL reset_sweep a=%0d: got %h/%h want 0/0", a, rd_data1, rd_data2);
      end
    end
  endtask

  task automatic test_basic;
    step(1'b1, 1'b1, 5'd0, 64'd32);
    step(1'b1, 1'b1, 5'd30, 64'd43);
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd30;
    #1;
    checks++;
    if (rd_data1 !== 64'd32 || rd_data2 !== 64'd43) begin
      failures++;
      $display("FAIL basic_rw: got %0d/%0d want 32/43", rd_data1, rd_data2);
    end
    for (int a = 1; a < 30; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(a);
      #1;
      checks++;
      if (rd_data1 !== 64'd0 || rd_data2 !== 64'd0) begin
        failures++;
        $display("FAIL basic_others a=%0d: got %h/%h want 0/0", a, rd_data1, rd_data2);
      end
    end
  endtask

  task automatic test_xzr;
    step(1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_addr1 = 5'd31;
    rd_addr2 = 5'd31;
    #1;
    checks++;
    if (rd_data1 !== 64'd0 || rd_data2 !== 64'd0) begin
      failures++;
      $display("FAIL xzr_read: got %h/%h want 0/0", rd_data1, rd_data2);
    end
    // Bypass must not forward a pending XZR write either.
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h1234_5678;
    #1;
    checks++;
    if (rd_data1 !== 64'd0) begin
      failures++;
      $display("FAIL xzr_pending: got %h want 0", rd_data1);
    end
    wr_en = 1'b0;
    for (int a = 0; a < 31; a++) begin
      rd_addr1 = 5'(a);
      #1;
      checks++;
      if (rd_data1 !== exp_rd(5'(a))) begin
        failures++;
        $display("FAIL xzr_sweep a=%0d: got %h want %h", a, rd_data1, exp_rd(5'(a)));
      end
    end
  endtask

  task automatic test_enable_low;
    step(1'b1, 1'b1, 5'd3, 64'h1234);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 5'd3, 64'h9999);
    step(1'b1, 1'b0, 5'bxxxxx, 64'hBAD0_BAD0);
    rd_addr1 = 5'd3;
    #1;
    checks++;
    if (rd_data1 !== 64'h1234) begin
      failures++;
      $display("FAIL enable_low_x3: got %h want %h", rd_data1, 64'h1234);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr2 = 5'(a);
      #1;
      checks++;
      if (rd_data2 !== exp_rd(5'(a))) begin
        failures++;
        $display("FAIL enable_low_sweep a=%0d: got %h want %h", a, rd_data2, exp_rd(5'(a)));
      end
    end
  endtask

  task automatic test_same_addr;
    logic [63:0] before_exp;
    step(1'b1, 1'b1, 5'd9, 64'd1);
`ifdef REG_FILE_WRITE_BYPASS_EN
    before_exp = 64'd2;
`else
    before_exp = 64'd1;
`endif
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'd2;
    rd_addr1 = 5'd9;
    rd_addr2 = 5'd9;
    #1;
    checks++;
    if (rd_data1 !== before_exp || rd_data2 !== before_exp) begin
      failures++;
      $display("FAIL same_addr_before: got %0d/%0d want %0d", rd_data1, rd_data2, before_exp);
    end
    step(1'b1, 1'b1, 5'd9, 64'd2);
    checks++;
    if (rd_data1 !== 64'd2) begin
      failures++;
      $display("FAIL same_addr_after: got %0d want 2", rd_data1);
    end
    // Forwarding is suppressed while reset is asserted.
    reset = 1'b0; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'd7;
    #1;
    checks++;
    if (rd_data1 !== 64'd2) begin
      failures++;
      $display("FAIL same_addr_in_reset: got %0d want 2", rd_data1);
    end
    reset = 1'b1; wr_en = 1'b0;
  endtask

  task automatic test_mid_reset;
    step(1'b1, 1'b1, 5'd1, 64'h11);
    step(1'b1, 1'b1, 5'd2, 64'h22);
    step(1'b0, 1'b1, 5'd3, 64'h33);
    for (int a = 1; a <= 4; a++) begin
      rd_addr1 = 5'(a);
      #1;
      checks++;
      if (rd_data1 !== 64'd0) begin
        failures++;
        $display("FAIL mid_reset_clear a=%0d: got %h want 0", a, rd_data1);
      end
    end
    step(1'b1, 1'b1, 5'd4, 64'h44);
    rd_addr1 = 5'd4;
    rd_addr2 = 5'd3;
    #1;
    checks++;
    if (rd_data1 !== 64'h44 || rd_data2 !== 64'd0) begin
      failures++;
      $display("FAIL mid_reset_after: got %h/%h want 44/0", rd_data1, rd_data2);
    end
  endtask

  task automatic test_random;
    logic        r;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 49) != 0);
      we = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      reset = r; wr_en = we; wr_addr = wa; wr_data = wd;
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rd_addr2 = ($urandom_range(0, 3) == 0) ? rd_addr1 : 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (rd_data1 !== exp_rd(rd_addr1) || rd_data2 !== exp_rd(rd_addr2)) begin
        failures++;
        $display("FAIL random n=%0d a1=%0d a2=%0d: got %h/%h want %h/%h", n, rd_addr1,
                 rd_addr2, rd_data1, rd_data2, exp_rd(rd_addr1), exp_rd(rd_addr2));
      end
      step(r, we, wa, wd);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      #1;
      checks++;
      if (rd_data1 !== exp_rd(5'(a))) begin
        failures++;
        $display("FAIL random_final a=%0d: got %h want %h", a, rd_data1, exp_rd(5'(a)));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    reset    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = 64'd0;
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd0;
    test_reset();
    test_basic();
    test_xzr();
    test_enable_low();
    test_same_addr();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
